// File: rtl/router_rx_sink.sv
// Receive side of one router output port. Drains the port FIFO, parses
// {len, addr} headers, streams header + payload downstream with SOP/EOP,
// checks parity and address, and keeps saturating good/bad packet counts.
module router_rx_sink #(
  parameter logic [1:0]  PORT_ID       = 2'd0,
  parameter int unsigned START_DELAY   = 0,
  parameter int unsigned ABORT_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vldout,
  input  logic [7:0]  data_out,
  output logic        read_enb,
  input  logic        down_ready,
  output logic [7:0]  pkt_data,
  output logic        pkt_vld,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic        pkt_done,
  output logic [5:0]  pkt_len,
  output logic        parity_err,
  output logic        addr_err,
  output logic        trunc_err,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned LoW       = $clog2(ABORT_TIMEOUT);
  localparam logic [LoW-1:0] AbortLast = LoW'(ABORT_TIMEOUT - 1);
  localparam logic [LoW-1:0] LoOne     = LoW'(1);
  localparam logic [4:0]     StartDly  = 5'(START_DELAY);

  typedef enum logic [1:0] {StIdle, StHdr, StBody, StCheck} state_e;

  // Output/skid entries are {sop, eop, data}.
  state_e         state_q, state_d;
  logic [4:0]     dly_cnt_q, dly_cnt_d;
  logic [LoW-1:0] lo_cnt_q, lo_cnt_d;
  logic [6:0]     req_left_q, req_left_d;
  logic [5:0]     rx_cnt_q, rx_cnt_d;
  logic [5:0]     len_q, len_d;
  logic [7:0]     par_q, par_d;
  logic           aerr_q, aerr_d;
  logic           perr_q, perr_d;
  logic           rd_pend_q, rd_pend_d;
  logic           read_enb_q, read_enb_d;
  logic [9:0]     out_q, out_d;
  logic           out_vld_q, out_vld_d;
  logic [9:0]     skid_q, skid_d;
  logic           skid_vld_q, skid_vld_d;
  logic           pkt_done_q, pkt_done_d;
  logic           parity_err_q, parity_err_d;
  logic           addr_err_q, addr_err_d;
  logic           trunc_err_q, trunc_err_d;
  logic [5:0]     pkt_len_q, pkt_len_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;
  logic [15:0]    err_cnt_q, err_cnt_d;

  logic           rd_acc;
  logic           abort;
  logic           push;
  logic [9:0]     push_ent;
  logic           xfer;

  assign rd_acc = read_enb_q && vldout;
  assign xfer   = out_vld_q && down_ready;

  // Packet FSM: header parse, payload/parity accounting, completion and abort.
  always_comb begin
    state_d      = state_q;
    dly_cnt_d    = dly_cnt_q;
    lo_cnt_d     = '0;
    req_left_d   = req_left_q;
    rx_cnt_d     = rx_cnt_q;
    len_d        = len_q;
    par_d        = par_q;
    aerr_d       = aerr_q;
    perr_d       = perr_q;
    rd_pend_d    = rd_acc;
    pkt_done_d   = 1'b0;
    parity_err_d = 1'b0;
    addr_err_d   = 1'b0;
    trunc_err_d  = 1'b0;
    pkt_len_d    = pkt_len_q;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;
    abort        = 1'b0;
    push         = 1'b0;
    push_ent     = '0;

    if (rd_acc) begin
      req_left_d = req_left_q - 7'd1;
    end

    // Consecutive vldout-low cycles while a packet is open.
    if ((state_q == StHdr || state_q == StBody) && !vldout) begin
      if (lo_cnt_q == AbortLast) begin
        abort = 1'b1;
      end else begin
        lo_cnt_d = lo_cnt_q + LoOne;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (vldout) begin
          if (dly_cnt_q == StartDly) begin
            state_d    = StHdr;
            req_left_d = 7'd1;
            dly_cnt_d  = '0;
          end else begin
            dly_cnt_d = dly_cnt_q + 5'd1;
          end
        end else begin
          dly_cnt_d = '0;
        end
      end
      StHdr: begin
        if (!abort && rd_pend_q) begin
          len_d      = data_out[7:2];
          par_d      = data_out;
          aerr_d     = (data_out[1:0] != PORT_ID);
          perr_d     = 1'b0;
          push       = 1'b1;
          push_ent   = {1'b1, (data_out[7:2] == 6'd0), data_out};
          req_left_d = {1'b0, data_out[7:2]} + 7'd1;
          rx_cnt_d   = '0;
          state_d    = StBody;
        end
      end
      StBody: begin
        if (!abort && rd_pend_q) begin
          if (rx_cnt_q == len_q) begin
            // Byte len+1 is the parity byte; it is checked, not forwarded.
            perr_d  = (par_q != data_out);
            state_d = StCheck;
          end else begin
            par_d    = par_q ^ data_out;
            push     = 1'b1;
            push_ent = {1'b0, (rx_cnt_q == len_q - 6'd1), data_out};
            rx_cnt_d = rx_cnt_q + 6'd1;
          end
        end
      end
      StCheck: begin
        pkt_done_d   = 1'b1;
        parity_err_d = perr_q;
        addr_err_d   = aerr_q;
        pkt_len_d    = len_q;
        if (perr_q || aerr_q) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else begin
          if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d     = StIdle;
      pkt_done_d  = 1'b1;
      trunc_err_d = 1'b1;
      req_left_d  = '0;
      rd_pend_d   = 1'b0;
      lo_cnt_d    = '0;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Output register plus one-entry skid; skid drains into the output first.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;

    if (xfer) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end

    if (abort) begin
      // Skid contents are discarded; terminate whatever is still held.
      skid_vld_d = 1'b0;
      if (out_vld_q && !xfer) begin
        out_d     = out_q;
        out_d[8]  = 1'b1;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push) begin
      if (!out_vld_d) begin
        out_d     = push_ent;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = push_ent;
        skid_vld_d = 1'b1;
      end
    end
  end

  // Issue a read only if the byte it returns is guaranteed a free slot even
  // if downstream stalls from now on.
  always_comb begin
    read_enb_d = (req_left_d != 7'd0) && !skid_vld_d && down_ready &&
                 !(out_vld_d && rd_pend_d);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      dly_cnt_q    <= '0;
      lo_cnt_q     <= '0;
      req_left_q   <= '0;
      rx_cnt_q     <= '0;
      len_q        <= '0;
      par_q        <= '0;
      aerr_q       <= 1'b0;
      perr_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      read_enb_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      trunc_err_q  <= 1'b0;
      pkt_len_q    <= '0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      req_left_q   <= req_left_d;
      rx_cnt_q     <= rx_cnt_d;
      len_q        <= len_d;
      par_q        <= par_d;
      aerr_q       <= aerr_d;
      perr_q       <= perr_d;
      rd_pend_q    <= rd_pend_d;
      read_enb_q   <= read_enb_d;
      pkt_done_q   <= pkt_done_d;
      parity_err_q <= parity_err_d;
      addr_err_q   <= addr_err_d;
      trunc_err_q  <= trunc_err_d;
      pkt_len_q    <= pkt_len_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Streaming data path registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign read_enb   = read_enb_q;
  assign pkt_data   = out_q[7:0];
  assign pkt_vld    = out_vld_q;
  assign pkt_sop    = out_vld_q && out_q[9];
  assign pkt_eop    = out_vld_q && out_q[8];
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign trunc_err  = trunc_err_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
